block_serial_cla_adder: RTL and testbench
=========================================

BLOCK_SERIAL_CLA_ADDER -- requirements
Module: block_serial_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter BLOCK, default 8: number of bits processed per cycle by one carry-lookahead group.
REQ-003 SHALL accept only WIDTH an integer multiple of BLOCK, with BLOCK >= 1; N = WIDTH/BLOCK is the number of chunks.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0 = A+B+cin; 1 = A-B, formed as A+~B+1.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1; for sub=1, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Function
REQ-006 SHALL implement a two-state FSM with states IDLE and RUN; busy = 1 exactly when the state is RUN.
REQ-007 SHALL accept start only on an edge where it is sampled high in IDLE; on that edge it captures a, B' = (sub ? ~b : b) and C = (sub ? 1 : cin), clears chunk index k to 0, and enters RUN.
REQ-008 SHALL ignore start while in RUN, with no effect on state, captured operands or outputs.
REQ-009 SHALL process chunk k (bits k*BLOCK+BLOCK-1 .. k*BLOCK) on each RUN edge and then increment k.
REQ-010 SHALL compute each chunk's sum bits as p^C_i, with p = a^B' and g = a&B'.
REQ-011 SHALL compute all internal carries of a chunk and its carry-out with full lookahead equations over g, p and the registered chunk carry-in, not by ripple.
REQ-012 SHALL register each chunk's carry-out as the carry-in of chunk k+1.
REQ-013 SHALL assemble result bits in an internal working register; the sum, cout and ovf outputs change only on the completion edge.
REQ-014 SHALL treat the edge that processes chunk N-1 as the completion edge; on that edge:
- sum is loaded from the working register.
- cout is loaded with the carry out of bit WIDTH-1.
- ovf is loaded with (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- the FSM returns to IDLE.
- done is set to 1.
REQ-015 SHALL hold done high for exactly one cycle after the completion edge.
REQ-016 SHALL have a latency from the start-accept edge to the completion edge of exactly N cycles; N = 1 is legal and completes on the first RUN edge.
REQ-017 SHALL accept start sampled high in the cycle in which done is high, since the FSM is in IDLE, giving back-to-back operations with one idle cycle between them.
REQ-018 SHALL hold sum, cout and ovf stable from one completion until the next completion or reset.
REQ-019 SHALL produce a result modulo 2^WIDTH with no truncation of any input bit.

Reset
REQ-020 SHALL, while rst is high, immediately and asynchronously force:
- the state to IDLE.
- busy = 0 and done = 0.
- sum = 0, cout = 0 and ovf = 0.
- k = 0, the chunk carry and the working register to 0.
REQ-021 SHALL abandon an operation interrupted by reset: no done pulse for it, and no partial result visible.
REQ-022 SHALL ignore start while rst is high; the first acceptable start is on the first edge after rst deasserts.

Verification
REQ-023 SHALL be checked, with WIDTH=32 and BLOCK=8, by these directed scenarios:
- start, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> done exactly 4 cycles after the accept edge; sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1.
- sub=1: a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=7, b=5 -> sum=0x00000002, cout=1, ovf=0; a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1.
- start pulsed at cycles 1 and 2 after accept -> ignored; new start held during the done cycle -> accepted; second result correct; first result stable until then.
- rst asserted 2 cycles into RUN -> outputs 0 immediately; no done; next operation correct.
- WIDTH=8, BLOCK=8: a=0xFF, b=0x00, cin=1 -> done 1 cycle after accept; sum=0x00, cout=1.

Source files
------------

// File: rtl/block_serial_cla_adder.sv
// Multi-cycle adder/subtractor: one BLOCK-bit carry-lookahead group per clock,
// with the chunk carry registered between cycles and the result published at completion.
module block_serial_cla_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / BLOCK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
      $error("block_serial_cla_adder: WIDTH must be a positive multiple of BLOCK");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] work_d;
   logic [KW-1:0]    k_q;
   logic             carry_q;

   logic [BLOCK-1:0] op_a;
   logic [BLOCK-1:0] op_b;
   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] chunk_sum;
   logic [BLOCK:0]   c;
   logic             acc;
   logic             last;
   logic             accept;
   logic             step;
   int               base;

   // Bit mask with ones at positions lo..hi; elaborates to a constant per term.
   function automatic logic [BLOCK-1:0] span(input int lo, input int hi);
      logic [BLOCK-1:0] m;
      m = '0;
      for (int t = 0; t < BLOCK; t++) begin
         m[t] = (t >= lo) && (t <= hi);
      end
      return m;
   endfunction

   // Chunk datapath: every carry is a flat sum of generate terms gated by
   // propagate products, so no carry depends on another carry of the chunk.
   always_comb begin
      base      = int'(k_q) * BLOCK;
      op_a      = a_q[base +: BLOCK];
      op_b      = b_q[base +: BLOCK];
      p         = op_a ^ op_b;
      g         = op_a & op_b;
      c         = '0;
      c[0]      = carry_q;
      acc       = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
         acc = g[i] | (carry_q & (&(p | ~span(0, i))));
         for (int j = 0; j < i; j++) begin
            acc = acc | (g[j] & (&(p | ~span(j + 1, i))));
         end
         c[i+1] = acc;
      end
      chunk_sum = p ^ c[BLOCK-1:0];
      work_d    = work_q;
      work_d[base +: BLOCK] = chunk_sum;
      last      = (k_q == KW'(N - 1));
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Subtraction is folded into capture: B' = ~b with carry-in forced to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            k_q     <= '0;
            work_q  <= '0;
         end else if (step) begin
            work_q  <= work_d;
            carry_q <= c[BLOCK];
            k_q     <= k_q + 1'b1;
            if (last) begin
               k_q  <= '0;
               sum  <= work_d;
               cout <= c[BLOCK];
               ovf  <= c[BLOCK-1] ^ c[BLOCK];
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_block_serial_cla_adder.sv
// Bench for block_serial_cla_adder: a 32/8 instance and an 8/8 instance, checked
// against an arithmetic reference model and directed corner cases.
module tb_block_serial_cla_adder;

   localparam int W       = 32;
   localparam int BK      = 8;
   localparam int NCH     = W / BK;
   localparam int TIMEOUT = 50;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          busy, done, cout, ovf;
   logic [W-1:0]  sum;

   logic          start8 = 1'b0;
   logic [7:0]    a8 = '0;
   logic [7:0]    b8 = '0;
   logic          cin8 = 1'b0;
   logic          sub8 = 1'b0;
   logic          busy8, done8, cout8, ovf8;
   logic [7:0]    sum8;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [W+1:0]  exp_q[$];   // {ovf, cout, sum}

   block_serial_cla_adder #(.WIDTH(W), .BLOCK(BK)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   block_serial_cla_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: plain wide addition; overflow from operand/result signs.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic sb);
      logic [W-1:0] yy;
      logic [W:0]   full;
      logic         o;
      yy   = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      o    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
      return {o, full[W], full[W-1:0]};
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // One full operation; inputs are scrambled after accept to prove capture.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic sb, input logic [W+1:0] expv, input string name);
      int           lat;
      logic [W+1:0] e;
      logic [W+1:0] prev;
      logic         hold_bad;
      @(negedge clk);
      prev  = {ovf, cout, sum};
      a     = av;
      b     = bv;
      cin   = ci;
      sub   = sb;
      start = 1'b1;
      exp_q.push_back(expv);
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      cin   = 1'($urandom_range(0, 1));
      sub   = 1'($urandom_range(0, 1));
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
      end
      lat      = 0;
      hold_bad = 1'b0;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         if ({ovf, cout, sum} !== prev) hold_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (lat != NCH) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, NCH);
      end
      n_checks++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL %s hold_during_run: outputs changed before completion, prev %h", name, prev);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({ovf, cout, sum} !== e) begin
         n_fail++;
         $display("FAIL %s result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                  name, ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy_at_done: got %b want 0", name, busy);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_width: got %b want 0", name, done);
      end
   endtask

   task automatic test_reset();
      start  = 1'b1;
      start8 = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, cout, ovf, sum} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
                  busy, done, cout, ovf, sum);
      end
      n_checks++;
      if ({busy8, done8, cout8, ovf8, sum8} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs8: got busy=%b done=%b sum=%h want all 0", busy8, done8, sum8);
      end
      start  = 1'b0;
      start8 = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_after_release: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_directed();
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, "add_wrap");
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, "add_ovf");
      do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, "sub_neg");
      do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0002}, "sub_pos");
      do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, "sub_ovf");
      do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2222_2222}, "add_cin");
   endtask

   task automatic test_random();
      logic [W-1:0] x, y;
      logic         ci, sb;
      for (int i = 0; i < 40; i++) begin
         x  = pick_operand();
         y  = pick_operand();
         ci = 1'($urandom_range(0, 1));
         sb = 1'($urandom_range(0, 1));
         do_op(x, y, ci, sb, model(x, y, ci, sb), "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] x1, y1, x2, y2;
      logic [W+1:0] e1, e2, e;
      int           lat;
      logic         hold_bad;
      x1 = $urandom; y1 = $urandom;
      x2 = $urandom; y2 = $urandom;
      e1 = model(x1, y1, 1'b1, 1'b0);
      e2 = model(x2, y2, 1'b0, 1'b1);
      @(negedge clk);
      a = x1; b = y1; cin = 1'b1; sub = 1'b0; start = 1'b1;
      exp_q.push_back(e1);
      lat = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         lat++;
         a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); start = 1'b1;
      end
      @(negedge clk);
      lat++;
      start = 1'b0;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (lat != NCH + 1) begin
         n_fail++;
         $display("FAIL b2b_first_latency: got %0d want %0d", lat - 1, NCH);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({ovf, cout, sum} !== e) begin
         n_fail++;
         $display("FAIL b2b_first_result: got %b %b %h want %b %b %h",
                  ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
      end
      a = x2; b = y2; cin = 1'b0; sub = 1'b1; start = 1'b1;
      exp_q.push_back(e2);
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept_in_done_cycle: got busy=%b want 1", busy);
      end
      lat      = 0;
      hold_bad = 1'b0;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         if ({ovf, cout, sum} !== e1) hold_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (hold_bad || lat != NCH) begin
         n_fail++;
         $display("FAIL b2b_first_stable: hold_bad=%b latency=%0d want 0/%0d", hold_bad, lat, NCH);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({ovf, cout, sum} !== e) begin
         n_fail++;
         $display("FAIL b2b_second_result: got %b %b %h want %b %b %h",
                  ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] x, y;
      logic         saw_done;
      do_op(32'h0F0F_0F0F, 32'h1111_1111, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2020_2020}, "pre_reset");
      @(negedge clk);
      a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, cout, ovf, sum} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run_async: got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
                  busy, done, cout, ovf, sum);
      end
      @(negedge clk);
      rst      = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done !== 1'b0 || sum !== '0) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL reset_mid_run_abandon: got done/partial sum after reset, want none");
      end
      x = $urandom; y = $urandom;
      do_op(x, y, 1'b1, 1'b0, model(x, y, 1'b1, 1'b0), "post_reset");
   endtask

   task automatic test_single_chunk();
      logic [7:0] x, y, yy;
      logic [8:0] full;
      logic       ci, sb, o;
      int         lat;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin
            x = 8'hFF; y = 8'h00; ci = 1'b1; sb = 1'b0;
         end else begin
            x = 8'($urandom); y = 8'($urandom);
            ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
         end
         yy   = sb ? ~y : y;
         full = {1'b0, x} + {1'b0, yy} + {8'h00, (sb ? 1'b1 : ci)};
         o    = (x[7] == yy[7]) && (full[7] != x[7]);
         @(negedge clk);
         a8 = x; b8 = y; cin8 = ci; sub8 = sb; start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom);
         lat = 0;
         while (done8 !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
         end
         n_checks++;
         if (lat != 1) begin
            n_fail++;
            $display("FAIL single_chunk_latency: got %0d want 1", lat);
         end
         n_checks++;
         if ({ovf8, cout8, sum8} !== {o, full[8], full[7:0]}) begin
            n_fail++;
            $display("FAIL single_chunk_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     ovf8, cout8, sum8, o, full[8], full[7:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      test_single_chunk();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
